tlu_dut_handshake: RTL

// Per-DUT-port trigger handshake engine in the TLU firmware; one instance drives each DUT_TRIGGER/DUT_RESET pair.

---
 rtl/tlu_dut_handshake_pkg.sv | 31 +++
 rtl/tlu_dut_handshake_input_sync.sv | 33 +++
 rtl/tlu_dut_handshake.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/tlu_dut_handshake_pkg.sv
// Shared types for the TLU per-DUT-port trigger handshake engine:
// handshake mode encodings, FSM state encoding and a mode decode helper.
package tlu_dut_handshake_pkg;

  typedef enum logic [1:0] {
    MODE_NONE   = 2'd0,
    MODE_SIMPLE = 2'd1,
    MODE_DATA   = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_t;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_PULSE        = 3'd1,
    ST_WAIT_BUSY_HI = 3'd2,
    ST_SHIFT        = 3'd3,
    ST_WAIT_BUSY_LO = 3'd4
  } state_t;

  // The reserved encoding behaves exactly like the no-handshake mode.
  function automatic mode_t decode_mode(input logic [1:0] raw);
    mode_t m;
    case (raw)
      2'd1:    m = MODE_SIMPLE;
      2'd2:    m = MODE_DATA;
      default: m = MODE_NONE;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/tlu_dut_handshake_input_sync.sv
// Two-flop synchroniser for an asynchronous DUT line, followed by a third
// flop used for rise/fall edge detection of the synchronised level.
module tlu_dut_handshake_input_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Synchroniser chain plus one history flop for edge detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= pin;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level = sync_q;
  assign rise  = sync_q & ~prev_q;
  assign fall  = ~sync_q & prev_q;

endmodule

// File: rtl/tlu_dut_handshake.sv
// Per-DUT-port trigger handshake engine: accepts a trigger request, runs the
// selected handshake on DUT_TRIGGER/DUT_BUSY/DUT_CLOCK, reports busy and
// timeouts, and generates an independent DUT_RESET pulse.
module tlu_dut_handshake
  import tlu_dut_handshake_pkg::*;
#(
  parameter int TRIG_NUM_BITS = 15,
  parameter int TIMEOUT_BITS  = 16,
  parameter int PULSE_CYCLES  = 4,
  parameter int RESET_CYCLES  = 8
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     ENABLE,
  input  logic [1:0]               MODE,
  input  logic [TIMEOUT_BITS-1:0]  TIMEOUT,
  input  logic                     TRIG_REQ,
  input  logic [TRIG_NUM_BITS-1:0] TRIG_NUM,
  output logic                     TRIG_ACK,
  output logic                     PORT_BUSY,
  output logic                     TIMEOUT_ERR,
  input  logic                     RESET_REQ,
  output logic                     DUT_TRIGGER,
  output logic                     DUT_RESET,
  input  logic                     DUT_BUSY,
  input  logic                     DUT_CLOCK
);

  localparam int BIT_W = $clog2(TRIG_NUM_BITS + 1);
  localparam int RST_W = $clog2(RESET_CYCLES + 1);

  state_t                   state_q, state_nxt;
  mode_t                    mode_q;
  logic [TIMEOUT_BITS-1:0]  cnt_q;
  logic [TRIG_NUM_BITS-1:0] sr_q;
  logic [BIT_W-1:0]         bit_q;
  logic                     trig_q, trig_nxt;
  logic                     rreq_q;
  logic [RST_W-1:0]         rcnt_q;

  logic ack, tout_err, cnt_clr, shift_step, tout_hit;
  logic busy_s, busy_rise, busy_fall;
  logic clk_level, clk_rise, clk_fall;
  logic unused_sync;

  tlu_dut_handshake_input_sync u_busy_sync (
    .clk   (CLK),
    .rst_n (RST_N),
    .pin   (DUT_BUSY),
    .level (busy_s),
    .rise  (busy_rise),
    .fall  (busy_fall)
  );

  tlu_dut_handshake_input_sync u_clk_sync (
    .clk   (CLK),
    .rst_n (RST_N),
    .pin   (DUT_CLOCK),
    .level (clk_level),
    .rise  (clk_rise),
    .fall  (clk_fall)
  );

  // Busy is consumed as a level; the DUT clock only by its rising edge.
  assign unused_sync = busy_rise | busy_fall | clk_level | clk_fall;

  assign tout_hit = (TIMEOUT != '0) && (cnt_q >= TIMEOUT);

  // Handshake FSM state register.
  always_ff @(posedge CLK) begin
    if (!RST_N) state_q <= ST_IDLE;
    else        state_q <= state_nxt;
  end

  // Next-state, trigger line value and per-cycle strobes.
  always_comb begin
    state_nxt  = state_q;
    trig_nxt   = trig_q;
    ack        = 1'b0;
    tout_err   = 1'b0;
    cnt_clr    = 1'b0;
    shift_step = 1'b0;
    case (state_q)
      ST_IDLE: begin
        trig_nxt = 1'b0;
        if (ENABLE && TRIG_REQ) begin
          ack       = 1'b1;
          trig_nxt  = 1'b1;
          state_nxt = (decode_mode(MODE) == MODE_NONE) ? ST_PULSE : ST_WAIT_BUSY_HI;
        end
      end
      ST_PULSE: begin
        if (cnt_q == TIMEOUT_BITS'(PULSE_CYCLES - 1)) begin
          trig_nxt  = 1'b0;
          state_nxt = ST_IDLE;
        end
      end
      ST_WAIT_BUSY_HI: begin
        if (busy_s) begin
          trig_nxt  = 1'b0;
          state_nxt = (mode_q == MODE_DATA) ? ST_SHIFT : ST_WAIT_BUSY_LO;
        end else if (tout_hit) begin
          tout_err  = 1'b1;
          trig_nxt  = 1'b0;
          state_nxt = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (clk_rise) begin
          cnt_clr = 1'b1;
          if (bit_q == BIT_W'(TRIG_NUM_BITS)) begin
            trig_nxt  = 1'b0;
            state_nxt = ST_WAIT_BUSY_LO;
          end else begin
            trig_nxt   = sr_q[0];
            shift_step = 1'b1;
          end
        end else if (tout_hit) begin
          tout_err  = 1'b1;
          trig_nxt  = 1'b0;
          state_nxt = ST_IDLE;
        end
      end
      ST_WAIT_BUSY_LO: begin
        trig_nxt = 1'b0;
        if (!busy_s) begin
          state_nxt = ST_IDLE;
        end else if (tout_hit) begin
          tout_err  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        trig_nxt  = 1'b0;
        state_nxt = ST_IDLE;
      end
    endcase
    if (state_nxt != state_q) cnt_clr = 1'b1;
  end

  // Trigger line, saturating wait counter, latched mode and trigger-number shifter.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      trig_q <= 1'b0;
      cnt_q  <= '0;
      mode_q <= MODE_NONE;
      sr_q   <= '0;
      bit_q  <= '0;
    end else begin
      trig_q <= trig_nxt;
      if (cnt_clr)          cnt_q <= '0;
      else if (cnt_q != '1) cnt_q <= cnt_q + TIMEOUT_BITS'(1);
      if (ack) begin
        mode_q <= decode_mode(MODE);
        sr_q   <= TRIG_NUM;
        bit_q  <= '0;
      end else if (shift_step) begin
        sr_q  <= sr_q >> 1;
        bit_q <= bit_q + BIT_W'(1);
      end
    end
  end

  // DUT reset pulse: each RESET_REQ rise (re)loads the down-counter.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      rreq_q <= 1'b0;
      rcnt_q <= '0;
    end else begin
      rreq_q <= RESET_REQ;
      if (RESET_REQ && !rreq_q) rcnt_q <= RST_W'(RESET_CYCLES);
      else if (rcnt_q != '0)    rcnt_q <= rcnt_q - RST_W'(1);
    end
  end

  // Strobes are gated by reset so nothing is reported while RST_N is low.
  assign TRIG_ACK    = ack & RST_N;
  assign TIMEOUT_ERR = tout_err & RST_N;
  assign PORT_BUSY   = (state_q != ST_IDLE);
  assign DUT_TRIGGER = trig_q;
  assign DUT_RESET   = (rcnt_q != '0);

endmodule
